// File: rtl/adder_pipe_if.sv
// ---------------------------------------------------------------------------
// adder_pipe_if
//
// Handshake and data bundle for adder_pipe.
//
// Valid/ready rule, on both sides: a beat moves on a rising clock edge when
// its valid and the matching ready are both high in the cycle before that
// edge. Valid never waits for ready. The producer holds its payload for as
// long as valid stays high and no transfer has happened. o_ready is derived
// from i_ready and pipeline occupancy only, so it never depends on i_valid.
//
//   input side  : i_valid, o_ready, i_a, i_b, i_c, i_sub
//   output side : o_valid, i_ready, o_s, o_c, o_ovf
//
// modport slave  : the adder's view
// modport master : the view of the environment that drives operands and
//                  consumes results
// ---------------------------------------------------------------------------
interface adder_pipe_if #(
    parameter int BW_DATA = 32
);
    // Operand side
    logic               i_valid;
    logic               o_ready;
    logic [BW_DATA-1:0] i_a;
    logic [BW_DATA-1:0] i_b;
    logic               i_c;
    logic               i_sub;

    // Result side
    logic               o_valid;
    logic               i_ready;
    logic [BW_DATA-1:0] o_s;
    logic               o_c;
    logic               o_ovf;

    modport slave (
        input  i_valid, i_a, i_b, i_c, i_sub, i_ready,
        output o_ready, o_valid, o_s, o_c, o_ovf
    );

    modport master (
        output i_valid, i_a, i_b, i_c, i_sub, i_ready,
        input  o_ready, o_valid, o_s, o_c, o_ovf
    );
endinterface

// File: rtl/adder_pipe.sv
// ---------------------------------------------------------------------------
// adder_pipe
//
// Pipelined adder/subtractor. The BW_DATA-bit carry chain is cut into
// N_STAGE chunks of BW_CHUNK = BW_DATA/N_STAGE bits. Stage k adds chunk k.
//
//   add : {o_c, o_s} = a + b + c
//   sub : {o_c, o_s} = a + ~b + ~c   (o_s = a - b - c, o_c = NOT borrow)
//   o_ovf : signed two's-complement overflow of the final result
//
// Ports
//   i_clk : clock; all state changes on its rising edge
//   i_rst : asynchronous, active-high reset; clears all state and drops beats
//   bus   : adder_pipe_if.slave (operand and result handshakes, data)
//
// Stage register contents (stage k):
//   v_q      : stage holds a beat
//   s_q      : completed sum chunks 0..k, (k+1)*BW_CHUNK bits
//   c_q      : carry out of chunk k
//   a_rem_q  : operand A chunks k+1..N_STAGE-1, not yet added
//   bp_rem_q : B' chunks k+1..N_STAGE-1 (B' = ~B when subtracting)
// The operand remainders shrink by one chunk per stage, and the completed
// sum grows by one chunk per stage. The last stage holds the full result,
// which drives the output directly, so the outputs stay stable during a
// stall.
//
// Flow control collapses bubbles. A stage loads when it is empty or when
// its content leaves this cycle. The last stage's content leaves when
// i_ready is high. Stage k-1's content leaves when stage k loads.
// ---------------------------------------------------------------------------
module adder_pipe #(
    parameter int BW_DATA = 32,
    parameter int N_STAGE = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    adder_pipe_if.slave  bus
);

    localparam int BW_CHUNK = BW_DATA / N_STAGE;

    if ((N_STAGE < 1) || (N_STAGE > BW_DATA) || ((BW_DATA % N_STAGE) != 0)) begin : g_bad_param
        $error("adder_pipe: BW_DATA must be a multiple of N_STAGE and 1 <= N_STAGE <= BW_DATA");
    end

    logic [N_STAGE-1:0] valid_q;   // occupancy of each stage
    logic [N_STAGE-1:0] load;      // stage k captures its upstream content

    // ------------------------------------------------------------------
    // Load enables, computed from the output end back to the input.
    // "take" means that the stage downstream of k will empty this cycle.
    // For the last stage, "take" is i_ready.
    // ------------------------------------------------------------------
    always_comb begin
        logic take;
        take = bus.i_ready;
        load = '0;
        for (int k = N_STAGE - 1; k >= 0; k--) begin
            load[k] = ~valid_q[k] | take;
            take    = load[k];
        end
    end

    assign bus.o_ready = load[0];
    assign bus.o_valid = valid_q[N_STAGE-1];

    // ------------------------------------------------------------------
    // Stages
    // ------------------------------------------------------------------
    for (genvar k = 0; k < N_STAGE; k++) begin : g_stage
        localparam int IN_W  = BW_DATA - k * BW_CHUNK;   // operand bits still to add
        localparam int OUT_W = (k + 1) * BW_CHUNK;       // sum bits complete after this stage

        logic [IN_W-1:0]     a_in;
        logic [IN_W-1:0]     bp_in;
        logic                cin;
        logic                vin;
        logic [BW_CHUNK:0]   chunk_sum;
        logic [OUT_W-1:0]    s_next;

        logic                v_q;
        logic                c_q;
        logic [OUT_W-1:0]    s_q;

        if (k == 0) begin : g_src
            // In subtract mode, B is inverted and the borrow-in becomes
            // carry-in = ~i_c. This makes the chain compute a + ~b + ~c.
            assign a_in   = bus.i_a;
            assign bp_in  = bus.i_sub ? ~bus.i_b : bus.i_b;
            assign cin    = bus.i_sub ? ~bus.i_c : bus.i_c;
            assign vin    = bus.i_valid;
            assign s_next = chunk_sum[BW_CHUNK-1:0];
        end else begin : g_src
            assign a_in   = g_stage[k-1].g_rem.a_rem_q;
            assign bp_in  = g_stage[k-1].g_rem.bp_rem_q;
            assign cin    = g_stage[k-1].c_q;
            assign vin    = g_stage[k-1].v_q;
            assign s_next = {chunk_sum[BW_CHUNK-1:0], g_stage[k-1].s_q};
        end

        assign chunk_sum = {1'b0, a_in[BW_CHUNK-1:0]}
                         + {1'b0, bp_in[BW_CHUNK-1:0]}
                         + {{BW_CHUNK{1'b0}}, cin};

        // When a bubble is loaded, only the valid bit is cleared. The data
        // registers keep their old contents.
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (load[k]) begin
                v_q <= vin;
                if (vin) begin
                    c_q <= chunk_sum[BW_CHUNK];
                    s_q <= s_next;
                end
            end
        end

        assign valid_q[k] = v_q;

        if (k < N_STAGE - 1) begin : g_rem
            // Upper chunks that have not been added yet move to the next
            // stage. Each stage drops the chunk it has just consumed.
            logic [IN_W-BW_CHUNK-1:0] a_rem_q;
            logic [IN_W-BW_CHUNK-1:0] bp_rem_q;

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    a_rem_q  <= '0;
                    bp_rem_q <= '0;
                end else if (load[k] && vin) begin
                    a_rem_q  <= a_in[IN_W-1:BW_CHUNK];
                    bp_rem_q <= bp_in[IN_W-1:BW_CHUNK];
                end
            end
        end else begin : g_out
            // The last chunk holds the operand sign bits. Overflow occurs
            // when A and B' have the same sign and the sum has the other
            // sign.
            logic ovf_q;

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    ovf_q <= 1'b0;
                end else if (load[k] && vin) begin
                    ovf_q <= (a_in[IN_W-1] == bp_in[IN_W-1])
                          && (chunk_sum[BW_CHUNK-1] != a_in[IN_W-1]);
                end
            end

            assign bus.o_s   = s_q;
            assign bus.o_c   = c_q;
            assign bus.o_ovf = ovf_q;
        end
    end

endmodule

// File: tb/tb_adder_pipe.sv
// ---------------------------------------------------------------------------
// tb_adder_pipe
//
// Main DUT: BW_DATA=8, N_STAGE=2.
//   - reset values
//   - table of directed vectors with hand-computed results and latency
//   - backpressure sequence, back-to-back throughput, reset mid-stream
//   - random traffic checked against an arithmetic reference model
// Sweep DUTs: BW_DATA=32, N_STAGE=1,4,8, each run on random traffic.
// ---------------------------------------------------------------------------
module tb_adder_pipe;

    // ---------------- clock / reset ----------------
    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic sw_rst = 1'b1;

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the operands.
    // Returns {s[63:0], carry/not-borrow, signed overflow}.
    function automatic logic [65:0] model(input int bw, input longint unsigned a,
                                          input longint unsigned b, input bit c, input bit sub);
        longint unsigned mask;
        longint unsigned s;
        bit              co;
        bit              ovf;
        longint          half;
        longint          sa;
        longint          sb;
        longint          ci;
        longint          r;
        mask = (64'd1 << bw) - 64'd1;
        ci   = c ? 64'sd1 : 64'sd0;
        if (!sub) begin
            s  = a + b + longint'(ci);
            co = ((s >> bw) & 64'd1) != 0;
        end else begin
            s  = a - b - longint'(ci);
            co = (a >= b + longint'(ci));
        end
        half = 64'sd1 <<< (bw - 1);
        sa   = (a >= longint'(half)) ? longint'(a) - 2 * half : longint'(a);
        sb   = (b >= longint'(half)) ? longint'(b) - 2 * half : longint'(b);
        r    = sub ? (sa - sb - ci) : (sa + sb + ci);
        ovf  = (r >= half) || (r < -half);
        return {s & mask, co, ovf};
    endfunction

    function automatic logic [63:0] pack_exp(input logic [65:0] e);
        return {e[63:2], e[1:0]};   // s fits in 32 bits for all DUTs here
    endfunction

    // ---------------- main DUT (8-bit, 2 stages) ----------------
    adder_pipe_if #(.BW_DATA(8)) bus8 ();

    adder_pipe #(.BW_DATA(8), .N_STAGE(2)) dut8 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus8)
    );

    // Scoreboard for the main DUT
    logic [65:0] exp_q[$];
    int          n_rx = 0;

    always @(negedge clk) begin : mon8
        logic [65:0] e;
        if (!rst) begin
            if (bus8.o_valid && bus8.i_ready) begin
                if (exp_q.size() == 0) begin
                    check("dut8_unexpected_beat", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("dut8_result", 64'({bus8.o_s, bus8.o_c, bus8.o_ovf}), pack_exp(e));
                end
                n_rx++;
            end
            if (bus8.i_valid && bus8.o_ready)
                exp_q.push_back(model(8, 64'(bus8.i_a), 64'(bus8.i_b), bus8.i_c, bus8.i_sub));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_beat(input logic [7:0] a, input logic [7:0] b, input logic c, input logic sub);
        bus8.i_a   = a;
        bus8.i_b   = b;
        bus8.i_c   = c;
        bus8.i_sub = sub;
    endtask

    task automatic rand_beat();
        set_beat(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    endtask

    task automatic drain8(input string name);
        bus8.i_valid = 1'b0;
        bus8.i_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- sweep DUTs (32-bit, N_STAGE = 1, 4, 8) ----------------
    localparam int SW_NS [3] = '{1, 4, 8};

    for (genvar g = 0; g < 3; g++) begin : g_sweep
        adder_pipe_if #(.BW_DATA(32)) sbus ();

        adder_pipe #(.BW_DATA(32), .N_STAGE(SW_NS[g])) dut (
            .i_clk (clk),
            .i_rst (sw_rst),
            .bus   (sbus)
        );

        logic [65:0] sq[$];
        bit          done = 1'b0;

        always @(negedge clk) begin : mon_sw
            logic [65:0] e;
            if (!sw_rst) begin
                if (sbus.o_valid && sbus.i_ready) begin
                    if (sq.size() == 0) begin
                        check($sformatf("sweep_n%0d_unexpected_beat", SW_NS[g]), 64'd1, 64'd0);
                    end else begin
                        e = sq.pop_front();
                        check($sformatf("sweep_n%0d_result", SW_NS[g]),
                              64'({sbus.o_s, sbus.o_c, sbus.o_ovf}), pack_exp(e));
                    end
                end
                if (sbus.i_valid && sbus.o_ready)
                    sq.push_back(model(32, 64'(sbus.i_a), 64'(sbus.i_b), sbus.i_c, sbus.i_sub));
            end
        end

        initial begin
            sbus.i_valid = 1'b0;
            sbus.i_ready = 1'b1;
            sbus.i_a     = '0;
            sbus.i_b     = '0;
            sbus.i_c     = 1'b0;
            sbus.i_sub   = 1'b0;
            wait (sw_rst == 1'b0);
            @(posedge clk);
            #1;
            repeat (400) begin
                sbus.i_valid = ($urandom_range(0, 3) != 0);
                sbus.i_ready = ($urandom_range(0, 3) != 0);
                sbus.i_a     = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : $urandom;
                sbus.i_b     = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
                sbus.i_c     = 1'($urandom);
                sbus.i_sub   = 1'($urandom);
                @(posedge clk);
                #1;
            end
            sbus.i_valid = 1'b0;
            sbus.i_ready = 1'b1;
            for (int i = 0; i < 40 && sq.size() != 0; i++) begin
                @(posedge clk);
                #1;
            end
            check($sformatf("sweep_n%0d_drain", SW_NS[g]), 64'(sq.size()), 64'd0);
            done = 1'b1;
        end
    end

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        logic       sub;
        logic [7:0] s;
        logic       co;
        logic       ovf;
    } vec_t;

    vec_t vecs[10];

    // ---------------- main test sequence ----------------
    initial begin
        bit          saw_full;
        bit          have_held;
        bit          accepted;
        bit          all_ready;
        bit          stale;
        logic [7:0]  held;
        logic [19:0] vseen;
        logic [19:0] vexp;
        int          sent;
        int          stall;
        int          rx0;

        //              a      b      c     sub    s      co    ovf
        vecs[0] = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};  // ripple across chunks
        vecs[1] = '{8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0};  // wrap with carry-in
        vecs[2] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};  // positive overflow
        vecs[3] = '{8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1, 1'b0};  // sub, no borrow
        vecs[4] = '{8'h00, 8'h01, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0};  // sub with borrow-in
        vecs[5] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};  // negative overflow
        vecs[6] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};  // -128 + -128
        vecs[7] = '{8'h7F, 8'hFF, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1};  // 127 - (-1)
        vecs[8] = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0};  // carry-in only
        vecs[9] = '{8'hFF, 8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};  // -1 - -1 - 1

        bus8.i_valid = 1'b0;
        bus8.i_ready = 1'b1;
        set_beat(8'h00, 8'h00, 1'b0, 1'b0);

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("reset_o_valid", 64'(bus8.o_valid), 64'd0);
        check("reset_o_s",     64'(bus8.o_s),     64'd0);
        check("reset_o_c",     64'(bus8.o_c),     64'd0);
        check("reset_o_ovf",   64'(bus8.o_ovf),   64'd0);
        rst    = 1'b0;
        sw_rst = 1'b0;
        @(posedge clk);
        #1;
        check("reset_o_ready", 64'(bus8.o_ready), 64'd1);

        // Directed vectors: accept at edge t; result shows after edge t+1
        for (int i = 0; i < 10; i++) begin
            set_beat(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].sub);
            bus8.i_valid = 1'b1;
            bus8.i_ready = 1'b1;
            @(posedge clk);
            #1;
            bus8.i_valid = 1'b0;
            rand_beat();
            check($sformatf("vec%0d_not_yet_valid", i), 64'(bus8.o_valid), 64'd0);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_valid", i), 64'(bus8.o_valid), 64'd1);
            check($sformatf("vec%0d_result", i),
                  64'({bus8.o_s, bus8.o_c, bus8.o_ovf}),
                  64'({vecs[i].s, vecs[i].co, vecs[i].ovf}));
        end
        drain8("directed_drain");

        // Backpressure: 10 beats, i_ready low for 5 cycles from the 2nd result
        saw_full  = 1'b0;
        have_held = 1'b0;
        held      = '0;
        sent      = 0;
        stall     = 0;
        rx0       = n_rx;
        for (int cyc = 0; cyc < 80 && (n_rx - rx0) < 10; cyc++) begin
            bus8.i_valid = (sent < 10);
            rand_beat();
            if ((n_rx - rx0) >= 1 && stall < 5) begin
                bus8.i_ready = 1'b0;
                stall++;
            end else begin
                bus8.i_ready = 1'b1;
            end
            @(negedge clk);
            accepted = bus8.i_valid && bus8.o_ready;
            if (!bus8.i_ready) begin
                if (!bus8.o_ready) saw_full = 1'b1;
                check("bp_valid_while_stalled", 64'(bus8.o_valid), 64'd1);
                if (have_held) check("bp_o_s_stable", 64'(bus8.o_s), 64'(held));
                held      = bus8.o_s;
                have_held = 1'b1;
            end
            @(posedge clk);
            #1;
            if (accepted) sent++;
        end
        check("bp_o_ready_fell", 64'(saw_full), 64'd1);
        check("bp_result_count", 64'(n_rx - rx0), 64'd10);
        drain8("bp_drain");

        // Back-to-back: 16 beats, o_valid high for 16 cycles from cycle 1
        all_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus8.i_valid = (i < 16);
            bus8.i_ready = 1'b1;
            rand_beat();
            if (!bus8.o_ready) all_ready = 1'b0;
            @(posedge clk);
            #1;
            vseen[i] = bus8.o_valid;
            vexp[i]  = (i >= 1) && (i <= 16);
        end
        check("b2b_valid_pattern", 64'(vseen), 64'(vexp));
        check("b2b_o_ready", 64'(all_ready), 64'd1);
        drain8("b2b_drain");

        // Reset with two beats in flight
        bus8.i_ready = 1'b1;
        bus8.i_valid = 1'b1;
        set_beat(8'h55, 8'h22, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        set_beat(8'h12, 8'h34, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        bus8.i_valid = 1'b0;
        check("rst_pre_valid", 64'(bus8.o_valid), 64'd1);
        check("rst_pre_o_s", 64'(bus8.o_s), 64'h77);
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("rst_mid_o_valid", 64'(bus8.o_valid), 64'd0);
        check("rst_mid_o_s", 64'(bus8.o_s), 64'd0);
        check("rst_mid_o_c", 64'(bus8.o_c), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst   = 1'b0;
        stale = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (bus8.o_valid) stale = 1'b1;
        end
        check("rst_no_stale", 64'(stale), 64'd0);
        check("rst_o_ready", 64'(bus8.o_ready), 64'd1);

        // Random traffic against the model
        repeat (300) begin
            bus8.i_valid = ($urandom_range(0, 3) != 0);
            bus8.i_ready = ($urandom_range(0, 3) != 0);
            rand_beat();
            @(posedge clk);
            #1;
        end
        drain8("random_drain");

        // Wait for the sweep instances, with a bound
        for (int i = 0; i < 3000 && !(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done); i++)
            @(posedge clk);
        check("sweep_complete",
              64'({g_sweep[0].done, g_sweep[1].done, g_sweep[2].done}), 64'b111);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute time limit
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
